// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one RAM port between instruction fetch and data access.
// Round-robin on contention, bounded wait per access, sticky fault flag.
module memory_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
  input  logic        ramerror,
  output logic        fault
);

  typedef enum logic [1:0] {S_IDLE, S_IACC, S_DACC, S_RESP} state_e;
  typedef enum logic {GNT_INSTR, GNT_DATA} grant_e;

  state_e      state_q, state_d;
  grant_e      last_q, last_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_q, store_d;
  logic        wr_q, wr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] iload_q, iload_d;
  logic [31:0] dload_q, dload_d;
  logic        fault_q, fault_d;
  logic        d_req;

  assign d_req = dREN | dWEN;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      last_q  <= GNT_INSTR;
      addr_q  <= '0;
      store_q <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      iload_q <= '0;
      dload_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    addr_d  = addr_q;
    store_d = store_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    iload_d = iload_q;
    dload_d = dload_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: begin
        // last_q also tags which requester the following RESP answers
        if (d_req && (!iREN || last_q == GNT_INSTR)) begin
          state_d = S_DACC;
          last_d  = GNT_DATA;
          addr_d  = daddr;
          store_d = dstore;
          wr_d    = dWEN;
          cnt_d   = '0;
        end else if (iREN) begin
          state_d = S_IACC;
          last_d  = GNT_INSTR;
          addr_d  = iaddr;
          wr_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      S_IACC, S_DACC: begin
        if (ramerror) begin
          state_d = S_RESP;
          fault_d = 1'b1;
        end else if (ramready) begin
          state_d = S_RESP;
          if (state_q == S_IACC)
            iload_d = ramload;
          else if (!wr_q)
            dload_d = ramload;
        end else if (cnt_q == TIMEOUT) begin
          state_d = S_RESP;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ramREN   = (state_q == S_IACC) || (state_q == S_DACC && !wr_q);
  assign ramWEN   = (state_q == S_DACC) && wr_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign ihit     = (state_q == S_RESP) && (last_q == GNT_INSTR);
  assign dhit     = (state_q == S_RESP) && (last_q == GNT_DATA);
  assign iload    = iload_q;
  assign dload    = dload_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized bench for memory_arbiter against a transaction-level model of
// grant order, access duration, load registers and the fault flag.
module tb_memory_arbiter;
  localparam logic [7:0] TO = 8'd4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN, ihit, dhit, ramREN, ramWEN, ramready, ramerror, fault;
  logic [31:0] iaddr, iload, daddr, dstore, dload, ramaddr, ramstore, ramload;

  always #5 CLK = ~CLK;

  memory_arbiter #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .ramerror(ramerror), .fault(fault)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  bit          m_last_data;
  logic [31:0] m_iload, m_dload;
  bit          m_fault;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    iREN = 0; dREN = 0; dWEN = 0; iaddr = '0; daddr = '0; dstore = '0;
    ramready = 0; ramerror = 0; ramload = '0;
    m_last_data = 0; m_iload = '0; m_dload = '0; m_fault = 0;
    #1;
    check("rst_ihit", ihit, 0);     check("rst_dhit", dhit, 0);
    check("rst_ramREN", ramREN, 0); check("rst_ramWEN", ramWEN, 0);
    check("rst_ramaddr", ramaddr, 0); check("rst_ramstore", ramstore, 0);
    check("rst_iload", iload, 0);   check("rst_dload", dload, 0);
    check("rst_fault", fault, 0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // One arbitration round. dly/err describe the RAM behaviour for the first
  // and second granted access; dly > TO means ramready never comes.
  task automatic transact(input bit want_i, input bit d_rd, input bit d_wr,
                          input logic [31:0] ia, input logic [31:0] da, input logic [31:0] ds,
                          input int unsigned dly0, input bit err0,
                          input int unsigned dly1, input bit err1,
                          input bit drop_loser);
    bit          want_d, cur_d, err;
    bit          order[$];
    logic [31:0] rl;
    int unsigned nacc, cyc, strobe_cyc, idx, dly, exp_cycles;
    want_d = d_rd | d_wr;
    if (want_d && want_i) begin
      order.push_back(!m_last_data);
      if (!drop_loser) order.push_back(m_last_data);
    end else begin
      order.push_back(want_d);
    end
    m_last_data = order[order.size()-1];
    iREN = want_i; iaddr = ia; dREN = d_rd; dWEN = d_wr; daddr = da; dstore = ds;
    rl = '0; nacc = 0; cyc = 0; strobe_cyc = 0; idx = 0;
    while (order.size() != 0 && cyc < 100) begin
      @(negedge CLK);
      cyc++;
      ramready = 0; ramerror = 0;
      cur_d = order[0];
      dly = (idx == 0) ? dly0 : dly1;
      err = (idx == 0) ? err0 : err1;
      if (ramREN || ramWEN) begin
        nacc++;
        strobe_cyc = cyc;
        check("ramaddr", ramaddr, cur_d ? da : ia);
        check("ramREN", ramREN, !(cur_d && d_wr));
        check("ramWEN", ramWEN, cur_d && d_wr);
        if (cur_d && d_wr) check("ramstore", ramstore, ds);
        if (drop_loser && nacc == 1) begin
          if (cur_d) iREN = 0;
          else begin dREN = 0; dWEN = 0; end
        end
        // current access must run from latched copies
        if (cur_d) begin daddr = $urandom; dstore = $urandom; end
        else iaddr = $urandom;
        if (nacc == dly + 1) begin
          if (err) begin
            ramerror = 1; ramready = 1'($urandom_range(0, 1)); ramload = $urandom;
          end else if (dly <= TO) begin
            rl = $urandom; ramready = 1; ramload = rl;
          end
        end
      end
      if (ihit || dhit) begin
        check("hit_kind", {30'b0, dhit, ihit}, cur_d ? 32'd2 : 32'd1);
        exp_cycles = (err || dly <= TO) ? dly + 1 : TO + 1;
        check("acc_cycles", nacc, exp_cycles);
        check("hit_timing", cyc, strobe_cyc + 1);
        if (idx == 0) check("latency", cyc, exp_cycles + 1);
        if (err || dly > TO) m_fault = 1;
        else if (!cur_d) m_iload = rl;
        else if (!d_wr) m_dload = rl;
        check("iload", iload, m_iload);
        check("dload", dload, m_dload);
        check("fault", fault, m_fault);
        if (cur_d) begin dREN = 0; dWEN = 0; end
        else iREN = 0;
        void'(order.pop_front());
        idx++;
        nacc = 0;
      end
    end
    check("pending", order.size(), 0);
    iREN = 0; dREN = 0; dWEN = 0;
    @(negedge CLK);
    check("idle_hits", {30'b0, ihit, dhit}, 0);
    check("idle_strobes", {30'b0, ramREN, ramWEN}, 0);
  endtask

  initial begin
    bit          wi, rd, wr, e0, e1, both;
    int unsigned d0, d1;
    do_reset();

    // single fetch, ramready in the first access cycle
    iREN = 1; iaddr = 32'h40;
    @(negedge CLK);
    check("f_ramREN", ramREN, 1); check("f_ramaddr", ramaddr, 32'h40);
    ramready = 1; ramload = 32'h8C010004;
    @(negedge CLK);
    ramready = 0; iREN = 0;
    check("f_ihit", ihit, 1); check("f_iload", iload, 32'h8C010004); check("f_ramREN_low", ramREN, 0);
    @(negedge CLK);
    check("f_ihit_pulse", ihit, 0);
    m_iload = 32'h8C010004;

    do_reset();
    transact(1, 1, 0, 32'h200, 32'h300, 32'h0, 0, 0, 1, 0, 0);
    transact(1, 1, 0, 32'h204, 32'h304, 32'h0, 2, 0, 0, 0, 0);
    transact(0, 1, 1, 32'h0, 32'h100, 32'hDEADBEEF, 1, 0, 0, 0, 0);
    transact(0, 1, 0, 32'h0, 32'h104, 32'h0, 9, 0, 0, 0, 0);
    transact(0, 1, 0, 32'h0, 32'h108, 32'h0, 0, 0, 0, 0, 0);
    transact(0, 1, 0, 32'h0, 32'h10C, 32'h0, 4, 0, 0, 0, 0);
    do_reset();
    transact(1, 0, 0, 32'h80, 32'h0, 32'h0, 1, 1, 0, 0, 0);

    // reset in the middle of a data access
    dREN = 1; daddr = 32'h500;
    @(negedge CLK);
    check("m_ramREN", ramREN, 1);
    @(negedge CLK);
    #2 RST = 1;
    #1;
    check("m_ramREN0", ramREN, 0); check("m_ramaddr0", ramaddr, 0);
    check("m_dhit", dhit, 0); check("m_fault0", fault, 0); check("m_dload0", dload, 0);
    @(negedge CLK);
    RST = 0; dREN = 0;
    m_last_data = 0; m_iload = '0; m_dload = '0; m_fault = 0;
    @(negedge CLK);
    check("m_nohit", {30'b0, ihit, dhit}, 0);
    transact(1, 1, 0, 32'h600, 32'h700, 32'h0, 0, 0, 0, 0, 0);
    transact(1, 1, 0, 32'h604, 32'h704, 32'h0, 1, 0, 0, 0, 1);

    for (int i = 0; i < 60; i++) begin
      wi = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 2) == 2);
      rd = wr ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 1));
      if (!wi && !rd && !wr) wi = 1;
      e0 = ($urandom_range(0, 7) == 0);
      e1 = ($urandom_range(0, 7) == 0);
      d0 = e0 ? $urandom_range(0, TO) : $urandom_range(0, TO + 1);
      d1 = e1 ? $urandom_range(0, TO) : $urandom_range(0, TO + 1);
      both = wi && (rd || wr) && ($urandom_range(0, 4) == 0);
      transact(wi, rd, wr, $urandom, $urandom, $urandom, d0, e0, d1, e1, both);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: the maximum number of cycles to wait for ramready per access (8-bit).
REQ-002 SHALL have port CLK, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port iREN, input, 1: instruction fetch request, held until ihit.
REQ-005 SHALL have port iaddr, input, 32: instruction word address.
REQ-006 SHALL have port iload, output, 32: fetched instruction word.
REQ-007 SHALL have port ihit, output, 1: one-cycle instruction completion pulse.
REQ-008 SHALL have ports dREN and dWEN, inputs, 1 each: data read and data write requests, held until dhit.
REQ-009 SHALL have ports daddr and dstore, inputs, 32 each: data address and write data.
REQ-010 SHALL have port dload, output, 32: read data.
REQ-011 SHALL have port dhit, output, 1: one-cycle data completion pulse.
REQ-012 SHALL have ports ramREN and ramWEN, outputs, 1 each: RAM strobes.
REQ-013 SHALL have ports ramaddr and ramstore, outputs, 32 each: RAM address and write data.
REQ-014 SHALL have port ramload, input, 32: RAM read data, valid when ramready=1.
REQ-015 SHALL have port ramready, input, 1: RAM access complete.
REQ-016 SHALL have port ramerror, input, 1: RAM access failed.
REQ-017 SHALL have port fault, output, 1: sticky error flag (ramerror or timeout).

Function
REQ-018 SHALL implement the FSM states IDLE, IACC, DACC and RESP.
REQ-019 IDLE: with only a data request (dREN|dWEN) pending, SHALL go to DACC; with only iREN pending, SHALL go to IACC; with none pending, SHALL stay in IDLE.
REQ-020 IDLE with both data and instruction pending SHALL grant the requester not granted last (last_grant register); last_grant resets to instruction, so data wins the first contention.
REQ-021 On grant SHALL latch the address, dstore, and op (write if dWEN=1, even when dREN=1 too); the RAM outputs are driven from latched values only.
REQ-022 IACC: ramREN=1, ramWEN=0. DACC: exactly one of ramREN/ramWEN=1, per the latched op. IDLE/RESP: both 0.
REQ-023 IACC/DACC with ramready=1 SHALL capture ramload into iload (IACC) or dload (DACC read) and go to RESP; a DACC write leaves dload unchanged.
REQ-024 RESP SHALL assert ihit or dhit (matching the access) for exactly one cycle, then return to IDLE; hit is never asserted outside RESP.
REQ-025 Minimum latency, request asserted in IDLE to hit: 3 cycles with ramready in the first access cycle; each extra wait cycle adds 1.
REQ-026 SHALL keep an 8-bit wait counter, cleared on entry to IACC/DACC and incremented each cycle there without ramready.
REQ-027 When the counter equals TIMEOUT without ramready, SHALL go to RESP, set fault, and leave the load register unchanged.
REQ-028 ramerror=1 in IACC/DACC SHALL go to RESP and set fault (ramready ignored that cycle).
REQ-029 fault SHALL stay 1 until reset, and arbitration SHALL continue normally after a fault.
REQ-030 Request inputs changing during IACC/DACC SHALL not affect the current access.
REQ-031 A request deasserted before its grant SHALL be dropped with no access issued.
REQ-032 Each grant in IDLE SHALL update last_grant; IDLE with no request leaves it unchanged.

Reset
REQ-033 RST=1 SHALL immediately force: state IDLE, ramREN=ramWEN=0, ihit=dhit=0, fault=0, iload=dload=0, ramaddr=ramstore=0, counter 0, last_grant=instruction.
REQ-034 RST asserted mid-access SHALL abort the access with no hit; the first request after release is granted from IDLE.

Verification
REQ-035 iREN=1, iaddr=0x40, ramready in 1st IACC cycle, ramload=0x8C010004 -> ihit at cycle 3, iload=0x8C010004, ramREN high 1 cycle.
REQ-036 iREN and dREN both asserted from reset -> DACC first (dhit), then IACC (ihit); a second contention grants instruction, then data.
REQ-037 dREN=dWEN=1, daddr=0x100, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramaddr=0x100, ramstore=0xDEADBEEF; dhit; dload unchanged.
REQ-038 TIMEOUT=4, ramready never asserted -> RESP after 4 wait cycles, dhit pulse, fault=1 held; a next access with ramready completes normally, fault still 1.
REQ-039 ramerror during IACC -> ihit pulse, fault=1; RST mid-DACC -> outputs zero asynchronously, no dhit, fault cleared.
